// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: execute-stage controller wrapped around an external 8-bit ALU.
// Holds a small register file. Accepts one instruction at a time over a
// valid/ready handshake, sequences the ALU operands, and writes the results back.
module alu_exec_ctrl #(
  parameter int NREG = 4,
  parameter int W    = 8,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [AW-1:0] instr_rs1,
  input  logic [AW-1:0] instr_rs2,
  input  logic [AW-1:0] instr_rd,
  input  logic          instr_imm_en,
  input  logic [W-1:0]  instr_imm,
  output logic [W-1:0]  alu_data1,
  output logic [W-1:0]  alu_data2,
  input  logic [W-1:0]  alu_result,
  input  logic          alu_zero,
  output logic          zero_flag,
  output logic          done,
  input  logic [AW-1:0] dbg_sel,
  output logic [W-1:0]  dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0] rs1_q, rs2_q, rd_q;
  logic          imm_en_q;
  logic [W-1:0]  imm_q;
  logic [W-1:0]  res_q;
  logic          zq;
  logic [W-1:0]  regs [NREG];

  logic accept;
  assign accept = instr_valid && instr_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and handshake ready.
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    unique case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = instr_imm_en ? WB : READ;
      end
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction latch, operand drive, result capture, and retire pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_en_q  <= 1'b0;
      imm_q     <= '0;
      alu_data1 <= '0;
      alu_data2 <= '0;
      res_q     <= '0;
      zq        <= 1'b0;
      zero_flag <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        rs1_q    <= instr_rs1;
        rs2_q    <= instr_rs2;
        rd_q     <= instr_rd;
        imm_en_q <= instr_imm_en;
        imm_q    <= instr_imm;
      end
      if (state == READ) begin
        alu_data1 <= regs[rs1_q];
        alu_data2 <= regs[rs2_q];
      end
      if (state == EXEC) begin
        res_q <= alu_result;
        zq    <= alu_zero;
      end
      if (state == WB) begin
        zero_flag <= imm_en_q ? (imm_q == '0) : zq;
        done      <= 1'b1;
      end
    end
  end

  // Register file: cleared on reset, written only in WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (state == WB) begin
      regs[rd_q] <= imm_en_q ? imm_q : res_q;
    end
  end

  assign dbg_data = regs[dbg_sel];

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Execute-stage controller that sits directly around the 8-bit ALU. It owns a small register file and accepts one instruction at a time over a valid/ready handshake. For each instruction it drives the ALU operand inputs (`data1`, `data2`), captures the ALU `result` and `zero` outputs, and writes the result and zero flag back. It also handles load-immediate instructions without using the ALU.

## Interface
- `NREG`, default 4: number of 8-bit registers; register index width is clog2(NREG) = 2.
- `W`, default 8: datapath width; must match the ALU.
- `clk`  in  1: single clock, rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `instr_valid`  in  1: an instruction is presented on the `instr_*` inputs.
- `instr_ready`  out  1: high only in IDLE; a transfer happens on a rising edge where `instr_valid` and `instr_ready` are both high.
- `instr_rs1`  in  2: source register for `data1`.
- `instr_rs2`  in  2: source register for `data2`.
- `instr_rd`  in  2: destination register.
- `instr_imm_en`  in  1: 1 = load immediate, 0 = ALU operation.
- `instr_imm`  in  W: immediate value.
- `alu_data1`  out  W: registered operand to ALU `data1`.
- `alu_data2`  out  W: registered operand to ALU `data2`.
- `alu_result`  in  W: from ALU `result` (combinational in ALU).
- `alu_zero`  in  1: from ALU `zero`.
- `zero_flag`  out  1: architectural zero flag.
- `done`  out  1: one-cycle pulse on instruction retirement.
- `dbg_sel`  in  2: debug read index.
- `dbg_data`  out  W: combinational `reg[dbg_sel]`.

## Operation
- **States:** IDLE, READ, EXEC, WB (2-bit encoding).
- **IDLE:** `instr_ready` = 1.
  - On handshake, latch rs1, rs2, rd, imm_en and imm into internal registers.
  - Next state is WB if imm_en = 1, otherwise READ.
  - `instr_valid` without a handshake is ignored.
- **READ:** `alu_data1` <= reg[rs1]; `alu_data2` <= reg[rs2]. Next state is EXEC.
- **EXEC:** the ALU has had one full cycle to settle. Capture res_q <= `alu_result` and zq <= `alu_zero`. Next state is WB.
- **WB, ALU op:** reg[rd] <= res_q; `zero_flag` <= zq.
- **WB, immediate:** reg[rd] <= imm; `zero_flag` <= (imm == 0).
- **WB, both cases:** `done` <= 1; next state is IDLE.
- `done` is registered: high for exactly the one cycle after the WB edge, and 0 otherwise.
- **Retained values:**
  - `alu_data1` and `alu_data2` hold their last values outside READ.
  - The ALU inputs are not modified by immediate loads.
- **Register aliasing:**
  - rd may equal rs1 and/or rs2. Operands are read in READ and written in WB, so the old value is used and the new value is stored.
  - rs1 == rs2 is legal.
- **Result width:** 8 bits; any carry out of the ALU is not stored. Wrap-around is the ALU's behaviour and is passed through unchanged.
- **No hazards:** only one instruction is in flight, so the next READ always sees the previous WB.

## Timing
- **Reset (async, while `rst` = 1):**
  - state = IDLE.
  - All registers = 0.
  - `alu_data1` = `alu_data2` = 0.
  - `zero_flag` = 0, `done` = 0.
  - `instr_ready` = 1 once `rst` deasserts. It is combinational from state, so it is also 1 during reset.
- **ALU-op latency:** accept edge → READ edge → EXEC edge → WB edge, i.e. 4 rising edges from accept to writeback.
  - `done` is high in the cycle after the 4th edge.
  - `instr_ready` rises in that same cycle.
  - Throughput is 1 instruction per 4 cycles.
- **Immediate latency:** accept edge → WB edge, i.e. 2 edges. Throughput is 1 per 2 cycles.
- `dbg_data` reflects a write in the cycle after the WB edge.
- **Back-to-back:** a new instruction may be accepted in the same cycle that `done` is high.
- **Reset mid-operation:** state returns to IDLE immediately. No writeback occurs, the register file is cleared, and the pending instruction is lost.

## Test plan
The bench stubs the ALU as result = data1 + data2 (mod 256) and zero = (result == 0).

- **Reset:** pulse `rst` mid-cycle (asynchronous) → `dbg_data` = 00 for sel 0–3, `zero_flag` = 0, `done` = 0, `instr_ready` = 1.
- **Immediate loads:** imm r0 = 8'h01, then r1 = 8'hFE → each `done` occurs 2 edges after accept; r0 = 01, r1 = FE; `zero_flag` = 0.
- **ALU op:** r2 = r0 + r1 → `alu_data1` = 01 and `alu_data2` = FE after the READ edge; r2 = FF; `zero_flag` = 0; `done` occurs 4 edges after accept; `instr_ready` = 0 for the 3 intermediate cycles.
- **Wrap and zero:** imm r3 = 02, then r2 = r3 + r1 → r2 = 00, `zero_flag` = 1. Then imm r0 = 05 → `zero_flag` = 0.
- **Hold and alias:**
  - `instr_valid` held high with a different instruction during EXEC → not accepted; accepted only in IDLE.
  - r0 = r0 + r0 with r0 = 05 → 0A.
- **Reset mid-op:** assert `rst` while in EXEC of r1 = r0 + r0 → no `done`, state IDLE, all registers 00, `alu_data1` and `alu_data2` = 00.
